// File: rtl/txrx_pkg.sv
// Shared packet definitions for the node's transmit and receive paths.
package txrx_pkg;

    localparam int PKT_W = 55;

    localparam logic [2:0] TYPE_TOKEN  = 3'b111;
    localparam logic [2:0] TYPE_ACK    = 3'b000;
    localparam logic [2:0] TYPE_NACK   = 3'b011;
    localparam logic [2:0] TYPE_DATA_C = 3'b010;
    localparam logic [2:0] TYPE_DATA_3 = 3'b001;

    typedef logic [PKT_W-1:0] pkt_t;

    // Which source owns the packet currently in flight on the serializer.
    typedef enum logic [1:0] {
        SRC_ACK,
        SRC_NACK,
        SRC_DATA,
        SRC_TOKEN
    } tx_src_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_state_e;

    function automatic logic is_data_type(input logic [2:0] t);
        return (t == TYPE_DATA_C) || (t == TYPE_DATA_3);
    endfunction

    // Control packets carry only a type code; the payload field is zero.
    function automatic pkt_t ctrl_pkt(input logic [2:0] t);
        return {t, {(PKT_W-3){1'b0}}};
    endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// Router-core requests, RX response indications and serializer handshake.
interface tx_scheduler_if;
    import txrx_pkg::*;

    logic ack_req;
    logic nack_req;
    logic token_req;
    logic data_req;
    pkt_t data_pkt;
    logic rx_ack;
    logic rx_nack;
    logic ready;
    logic start;
    pkt_t TX_Data;
    logic data_busy;
    logic data_done;
    logic data_fail;
    logic token_sent;

    modport master (
        input  ack_req, nack_req, token_req, data_req, data_pkt,
        input  rx_ack, rx_nack, ready,
        output start, TX_Data, data_busy, data_done, data_fail, token_sent
    );

    modport slave (
        output ack_req, nack_req, token_req, data_req, data_pkt,
        output rx_ack, rx_nack, ready,
        input  start, TX_Data, data_busy, data_done, data_fail, token_sent
    );

endinterface

// File: rtl/tx_resp_tracker.sv
// Remote-response tracking for the held DATA packet: response timeout,
// retry budget and the data_done / data_fail pulses.
module tx_resp_tracker
    import txrx_pkg::*;
#(
    parameter int MAX_RETRY    = 3,
    parameter int RESP_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic accept_i,
    input  logic reject_i,
    input  logic data_cmpl_i,
    input  logic rx_ack_i,
    input  logic rx_nack_i,
    output logic retry_o,
    output logic release_o,
    output logic data_done_o,
    output logic data_fail_o
);

    localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic             wait_resp_q, wait_resp_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic ack_ev;
    logic neg_ev;
    logic can_retry;
    logic give_up;

    // A simultaneous ACK+NACK is treated as NACK; ACK wins over a timeout
    // landing in the same cycle. The timer counts down from RESP_TIMEOUT,
    // so terminal count zero marks the cycle the elapsed count reaches it.
    always_comb begin
        ack_ev    = wait_resp_q && rx_ack_i && !rx_nack_i;
        neg_ev    = wait_resp_q && !ack_ev && (rx_nack_i || (tmr_q == '0));
        can_retry = (retry_q < RTY_W'(MAX_RETRY));
        retry_o   = neg_ev && can_retry;
        give_up   = neg_ev && !can_retry;
        release_o = ack_ev || give_up;
    end

    // Next-state for the wait flag, timer, retry count and status pulses.
    always_comb begin
        wait_resp_d = wait_resp_q;
        tmr_d       = tmr_q;
        retry_d     = retry_q;
        done_d      = ack_ev;
        fail_d      = reject_i || give_up;
        if (wait_resp_q && (tmr_q != '0)) begin
            tmr_d = tmr_q - 1'b1;
        end
        if (ack_ev || neg_ev) begin
            wait_resp_d = 1'b0;
        end
        if (retry_o) begin
            retry_d = retry_q + 1'b1;
        end
        if (accept_i) begin
            retry_d = '0;
        end
        if (data_cmpl_i) begin
            wait_resp_d = 1'b1;
            tmr_d       = TMR_W'(RESP_TIMEOUT);
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_resp_q <= 1'b0;
            tmr_q       <= '0;
            retry_q     <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            wait_resp_q <= wait_resp_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign data_done_o = done_q;
    assign data_fail_o = fail_q;

endmodule

// File: rtl/tx_scheduler.sv
// Transmit-path scheduler: arbitrates ACK, NACK, DATA and TOKEN packets onto
// the serializer start/ready handshake.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | waiting for an eligible request while serializer is ready
//   ST_LAUNCH    | start pulse high, TX_Data holds the winning packet
//   ST_WAIT_BUSY | waiting for ready to fall; relaunch if it never does
//   ST_WAIT_DONE | serializer busy; ready rising completes the packet
module tx_scheduler
    import txrx_pkg::*;
#(
    parameter int MAX_RETRY    = 3,
    parameter int RESP_TIMEOUT = 256,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    tx_scheduler_if.master sif
);

    localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);

    tx_state_e         state_q, state_d;
    tx_src_e           cur_q, cur_d;
    pkt_t              tx_data_q, tx_data_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              start_q, start_d;
    logic              tok_sent_q, tok_sent_d;
    logic              ack_p_q, ack_p_d;
    logic              nack_p_q, nack_p_d;
    logic              tok_p_q, tok_p_d;
    logic              data_p_q, data_p_d;
    logic              data_busy_q, data_busy_d;
    pkt_t              data_q, data_d;

    logic    accept;
    logic    reject;
    logic    cmpl;
    logic    data_cmpl;
    logic    retry;
    logic    data_release;
    logic    data_done;
    logic    data_fail;
    logic    any_elig;
    tx_src_e win_src;
    pkt_t    win_pkt;

    // Only DATA-typed requests are taken, and only while no DATA is held.
    always_comb begin
        accept = sif.data_req && !data_busy_q && is_data_type(sif.data_pkt[54:52]);
        reject = sif.data_req && !data_busy_q && !is_data_type(sif.data_pkt[54:52]);
    end

    // Fixed priority ACK > NACK > DATA > TOKEN; TOKEN waits out a held DATA.
    always_comb begin
        win_src  = SRC_TOKEN;
        win_pkt  = ctrl_pkt(TYPE_TOKEN);
        any_elig = ack_p_q || nack_p_q || data_p_q || (tok_p_q && !data_busy_q);
        if (ack_p_q) begin
            win_src = SRC_ACK;
            win_pkt = ctrl_pkt(TYPE_ACK);
        end else if (nack_p_q) begin
            win_src = SRC_NACK;
            win_pkt = ctrl_pkt(TYPE_NACK);
        end else if (data_p_q) begin
            win_src = SRC_DATA;
            win_pkt = data_q;
        end
    end

    // Launch sequencing FSM: next state, latched packet and busy timer.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tx_data_d  = tx_data_q;
        busy_cnt_d = busy_cnt_q;
        cmpl       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig && sif.ready) begin
                    cur_d     = win_src;
                    tx_data_d = win_pkt;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                busy_cnt_d = BUSY_W'(BUSY_TIMEOUT - 1);
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!sif.ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (busy_cnt_q == '0) begin
                    // Flag is still set, so IDLE relaunches the same packet.
                    state_d = ST_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (sif.ready) begin
                    cmpl    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        start_d = (state_d == ST_LAUNCH);
    end

    // Sticky request flags: completion clears, a coincident request re-sets.
    always_comb begin
        data_cmpl   = cmpl && (cur_q == SRC_DATA);
        tok_sent_d  = cmpl && (cur_q == SRC_TOKEN);
        ack_p_d     = (ack_p_q  && !(cmpl && (cur_q == SRC_ACK)))  || sif.ack_req;
        nack_p_d    = (nack_p_q && !(cmpl && (cur_q == SRC_NACK))) || sif.nack_req;
        tok_p_d     = (tok_p_q  && !tok_sent_d)                    || sif.token_req;
        data_p_d    = (data_p_q && !data_cmpl) || accept || retry;
        data_busy_d = (data_busy_q || accept) && !data_release;
        data_d      = accept ? sif.data_pkt : data_q;
    end

    // Scheduler state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= SRC_ACK;
            tx_data_q   <= '0;
            busy_cnt_q  <= '0;
            start_q     <= 1'b0;
            tok_sent_q  <= 1'b0;
            ack_p_q     <= 1'b0;
            nack_p_q    <= 1'b0;
            tok_p_q     <= 1'b0;
            data_p_q    <= 1'b0;
            data_busy_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            tx_data_q   <= tx_data_d;
            busy_cnt_q  <= busy_cnt_d;
            start_q     <= start_d;
            tok_sent_q  <= tok_sent_d;
            ack_p_q     <= ack_p_d;
            nack_p_q    <= nack_p_d;
            tok_p_q     <= tok_p_d;
            data_p_q    <= data_p_d;
            data_busy_q <= data_busy_d;
            data_q      <= data_d;
        end
    end

    tx_resp_tracker #(
        .MAX_RETRY    (MAX_RETRY),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) u_resp (
        .clk         (clk),
        .rst         (rst),
        .accept_i    (accept),
        .reject_i    (reject),
        .data_cmpl_i (data_cmpl),
        .rx_ack_i    (sif.rx_ack),
        .rx_nack_i   (sif.rx_nack),
        .retry_o     (retry),
        .release_o   (data_release),
        .data_done_o (data_done),
        .data_fail_o (data_fail)
    );

    assign sif.start      = start_q;
    assign sif.TX_Data    = tx_data_q;
    assign sif.data_busy  = data_busy_q;
    assign sif.data_done  = data_done;
    assign sif.data_fail  = data_fail;
    assign sif.token_sent = tok_sent_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with a small serializer model.
module tb_tx_scheduler;

    localparam int RESP_TO = 256;
    localparam int BUSY_TO = 8;
    localparam int MAXR    = 3;

    localparam logic [54:0] PK_TOKEN = {3'b111, 52'h0};
    localparam logic [54:0] PK_ACK   = {3'b000, 52'h0};
    localparam logic [54:0] D1       = {3'b010, 52'h1234_5678_9ABC_D};
    localparam logic [54:0] D2       = {3'b001, 52'hF_EDCB_A987_6543};
    localparam logic [54:0] D3       = {3'b010, 52'hA_5A5A_5A5A_5A5A};
    localparam logic [54:0] BADP     = {3'b111, 52'h0_0000_0000_00FF};

    logic clk = 1'b0;
    logic rst;

    tx_scheduler_if sif ();

    tx_scheduler #(
        .MAX_RETRY    (MAXR),
        .RESP_TIMEOUT (RESP_TO),
        .BUSY_TIMEOUT (BUSY_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          launch_cyc[$];
    logic [54:0] launch_pkt[$];
    int n_done = 0, n_fail = 0, n_tok = 0;
    int done_cyc = -1, fail_cyc = -1, tok_cyc = -1;
    int dbl_start = 0;
    logic prev_start = 1'b0;
    int ser_len = 4;
    int ser_cnt = 0;
    logic stuck = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serializer model and output monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (sif.start && prev_start) dbl_start++;
        prev_start = sif.start;
        if (sif.start) begin
            launch_cyc.push_back(cyc);
            launch_pkt.push_back(sif.TX_Data);
        end
        if (sif.data_done)  begin n_done++; done_cyc = cyc; end
        if (sif.data_fail)  begin n_fail++; fail_cyc = cyc; end
        if (sif.token_sent) begin n_tok++;  tok_cyc  = cyc; end
        if (!rst) begin
            sif.ready = 1'b1;
            ser_cnt   = 0;
        end else if (ser_cnt > 0) begin
            ser_cnt--;
            if (ser_cnt == 0) sif.ready = 1'b1;
        end else if (sif.start && !stuck) begin
            sif.ready = 1'b0;
            ser_cnt   = ser_len;
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on the selected request lines; m is the edge count
    // before the sampling edge.
    task automatic pulse(input logic a, input logic n, input logic t, input logic d,
                         input logic ra, input logic rn, output int m);
        m = cyc;
        sif.ack_req   = a;
        sif.nack_req  = n;
        sif.token_req = t;
        sif.data_req  = d;
        sif.rx_ack    = ra;
        sif.rx_nack   = rn;
        step(1);
        sif.ack_req   = 1'b0;
        sif.nack_req  = 1'b0;
        sif.token_req = 1'b0;
        sif.data_req  = 1'b0;
        sif.rx_ack    = 1'b0;
        sif.rx_nack   = 1'b0;
    endtask

    task automatic wait_launches(input string tag, input int target, input int budget);
        int k = 0;
        while (launch_cyc.size() < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 64'(launch_cyc.size() >= target), 64'd1);
    endtask

    function automatic int get_cnt(input int w);
        if (w == 0) return n_done;
        if (w == 1) return n_fail;
        return n_tok;
    endfunction

    task automatic wait_cnt(input string tag, input int w, input int target, input int budget);
        int k = 0;
        while (get_cnt(w) < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 64'(get_cnt(w)), 64'(target));
    endtask

    initial begin
        int m, m2, base, prev_tok;
        rst = 1'b0;
        sif.ack_req = 1'b0; sif.nack_req = 1'b0; sif.token_req = 1'b0;
        sif.data_req = 1'b0; sif.data_pkt = '0;
        sif.rx_ack = 1'b0; sif.rx_nack = 1'b0; sif.ready = 1'b1;
        step(3);
        chk("rst_start",     64'(sif.start),      64'd0);
        chk("rst_txdata",    64'(sif.TX_Data),    64'd0);
        chk("rst_busy",      64'(sif.data_busy),  64'd0);
        chk("rst_pulses",    64'({sif.data_done, sif.data_fail, sif.token_sent}), 64'd0);
        rst = 1'b1;
        step(2);

        // Token alone.
        pulse(0, 0, 1, 0, 0, 0, m);
        wait_launches("tok_launch", 1, 20);
        chk("tok_latency", 64'(launch_cyc[0]), 64'(m + 2));
        chk("tok_pkt",     64'(launch_pkt[0]), 64'(PK_TOKEN));
        wait_cnt("tok_sent", 2, 1, 20);
        chk("tok_sent_cyc", 64'(tok_cyc), 64'(launch_cyc[0] + ser_len + 1));
        step(10);
        chk("tok_once", 64'(launch_cyc.size()), 64'd1);

        // Stray rx_ack with nothing outstanding.
        pulse(0, 0, 0, 0, 1, 0, m);
        step(3);
        chk("stray_ack", 64'(n_done), 64'd0);

        // ACK + DATA-C + TOKEN together.
        sif.data_pkt = D1;
        pulse(1, 0, 1, 1, 0, 0, m);
        wait_launches("mix_launch", 3, 60);
        chk("mix_ack_cyc",  64'(launch_cyc[1]), 64'(m + 2));
        chk("mix_ack_pkt",  64'(launch_pkt[1]), 64'(PK_ACK));
        chk("mix_data_pkt", 64'(launch_pkt[2]), 64'(D1));
        chk("mix_data_cyc", 64'(launch_cyc[2]), 64'(launch_cyc[1] + ser_len + 2));
        step(15);
        chk("mix_tok_held", 64'(launch_cyc.size()), 64'd3);
        chk("mix_busy",     64'(sif.data_busy),     64'd1);
        pulse(0, 0, 0, 0, 1, 0, m2);
        wait_launches("mix_tok_launch", 4, 20);
        chk("mix_done_cyc", 64'(done_cyc),      64'(m2 + 1));
        chk("mix_tok_pkt",  64'(launch_pkt[3]), 64'(PK_TOKEN));
        chk("mix_tok_cyc",  64'(launch_cyc[3]), 64'(m2 + 2));
        chk("mix_unbusy",   64'(sif.data_busy), 64'd0);
        wait_cnt("mix_tok_sent", 2, 2, 20);

        // DATA-3 with three NACKs and then an ACK.
        base = launch_cyc.size();
        sif.data_pkt = D2;
        pulse(0, 0, 0, 1, 0, 0, m);
        for (int i = 0; i < 4; i++) begin
            wait_launches("nack_launch", base + i + 1, 40);
            chk("nack_pkt", 64'(launch_pkt[base + i]), 64'(D2));
            chk("nack_cyc", 64'(launch_cyc[base + i]), 64'(m + 2));
            step(6);
            if (i < 3) pulse(0, 0, 0, 0, 0, 1, m);
            else       pulse(0, 0, 0, 0, 1, 0, m);
        end
        wait_cnt("nack_done", 0, 2, 20);
        chk("nack_done_cyc", 64'(done_cyc), 64'(m + 1));
        chk("nack_no_fail",  64'(n_fail),   64'd0);
        step(10);
        chk("nack_count", 64'(launch_cyc.size()), 64'(base + 4));
        chk("nack_unbusy", 64'(sif.data_busy),    64'd0);

        // DATA-C with no response at all.
        base = launch_cyc.size();
        sif.data_pkt = D3;
        pulse(0, 0, 0, 1, 0, 0, m);
        wait_launches("to_launch", base + 1, 20);
        chk("to_first_cyc", 64'(launch_cyc[base]), 64'(m + 2));
        for (int i = 1; i < 4; i++) begin
            wait_launches("to_relaunch", base + i + 1, RESP_TO + 40);
            chk("to_spacing", 64'(launch_cyc[base + i]),
                64'(launch_cyc[base + i - 1] + RESP_TO + ser_len + 3));
        end
        wait_cnt("to_fail", 1, 1, RESP_TO + 40);
        chk("to_fail_cyc", 64'(fail_cyc), 64'(launch_cyc[base + 3] + ser_len + 2 + RESP_TO));
        chk("to_unbusy",   64'(sif.data_busy), 64'd0);
        step(10);
        chk("to_count", 64'(launch_cyc.size()), 64'(base + 4));

        // Serializer never drops ready: relaunch after the busy timeout.
        base = launch_cyc.size();
        prev_tok = n_tok;
        stuck = 1'b1;
        pulse(0, 0, 1, 0, 0, 0, m);
        wait_launches("stuck_launch", base + 1, 20);
        chk("stuck_first", 64'(launch_cyc[base]), 64'(m + 2));
        wait_launches("stuck_relaunch", base + 2, 30);
        chk("stuck_spacing", 64'(launch_cyc[base + 1]), 64'(launch_cyc[base] + BUSY_TO + 2));
        chk("stuck_pkt",     64'(launch_pkt[base + 1]), 64'(PK_TOKEN));
        stuck = 1'b0;
        wait_cnt("stuck_sent", 2, prev_tok + 1, 60);
        chk("stuck_count", 64'(launch_cyc.size()), 64'(base + 3));

        // Non-DATA type on data_req is rejected.
        base = launch_cyc.size();
        sif.data_pkt = BADP;
        pulse(0, 0, 0, 1, 0, 0, m);
        step(2);
        chk("rej_fail",     64'(n_fail),   64'd2);
        chk("rej_fail_cyc", 64'(fail_cyc), 64'(m + 1));
        step(10);
        chk("rej_no_launch", 64'(launch_cyc.size()), 64'(base));
        chk("rej_unbusy",    64'(sif.data_busy),     64'd0);

        // Reset while the serializer is busy with a DATA packet.
        ser_len = 30;
        base = launch_cyc.size();
        sif.data_pkt = D1;
        pulse(0, 0, 0, 1, 0, 0, m);
        wait_launches("rst_launch", base + 1, 20);
        step(4);
        chk("pre_rst_txdata", 64'(sif.TX_Data),   64'(D1));
        chk("pre_rst_busy",   64'(sif.data_busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_txdata", 64'(sif.TX_Data),   64'd0);
        chk("mid_rst_busy",   64'(sif.data_busy), 64'd0);
        chk("mid_rst_outs",   64'({sif.start, sif.data_done, sif.data_fail, sif.token_sent}), 64'd0);
        step(2);
        rst = 1'b1;
        ser_len = 4;
        step(2);
        base = launch_cyc.size();
        prev_tok = n_tok;
        pulse(0, 0, 1, 0, 0, 0, m);
        wait_launches("post_rst_launch", base + 1, 20);
        chk("post_rst_cyc", 64'(launch_cyc[base]), 64'(m + 2));
        chk("post_rst_pkt", 64'(launch_pkt[base]), 64'(PK_TOKEN));
        wait_cnt("post_rst_sent", 2, prev_tok + 1, 20);

        chk("no_double_start", 64'(dbl_start), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
